// File: rtl/exc_ctrl.sv
// exc_ctrl -- MEM-stage exception/interrupt controller.
//
// Picks one winning event per MEM instruction and sends a one-cycle
// one-hot pulse to CP0 (FLUSH state). It then requests a fetch redirect
// to EXC_VECTOR, or to EPC for eret, and holds the request until fetch
// accepts it (REDIRECT state).
//
// Optional feature: define EXC_INT_EN to enable the 2-flop interrupt
// synchronizer and int_flag_o. Without it, int_i is ignored and no
// interrupt is ever taken.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_valid_i              MEM holds a real instruction
//   mem_pc_i, mem_delayslot_i  PC / delay-slot bit of MEM instruction
//   mem_*_i                  per-instruction event flags
//   int_i                    asynchronous hardware interrupt lines
//   status_i, epc_i          CP0 Status (IE, EXL, IM7..IM2) and EPC
//   fetch_ready_i            fetch accepts the redirect this cycle
//   *_flag_o                 one-hot event pulses to CP0
//   delayslot_flag_o         delay-slot bit of the pulsed event
//   current_pc_addr_o        PC of the pulsed instruction
//   flush_o, stall_o         pipeline kill / freeze
//   redirect_valid_o/pc_o    redirect request to fetch
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delayslot_i,
  input  logic        mem_syscall_i,
  input  logic        mem_break_i,
  input  logic        mem_overflow_i,
  input  logic        mem_adel_i,
  input  logic        mem_ades_i,
  input  logic        mem_eret_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] epc_i,
  input  logic        fetch_ready_i,
  output logic        syscall_flag_o,
  output logic        break_flag_o,
  output logic        overflow_flag_o,
  output logic        addr_read_error_flag_o,
  output logic        addr_write_error_flag_o,
  output logic        eret_flag_o,
  output logic        int_flag_o,
  output logic        delayslot_flag_o,
  output logic [31:0] current_pc_addr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_REDIRECT} state_t;

  state_t      r_state, w_next;
  // Event one-hot, bit order {int, adel, ades, overflow, syscall, break, eret}
  logic [6:0]  r_evt, w_evt;
  logic [31:0] r_pc, r_target;
  logic        r_ds;
  logic        w_int_pend;
  logic        w_take;

`ifdef EXC_INT_EN
  logic [5:0] r_int_s1, r_int_s2;
  logic       w_unused_status;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_s1 <= '0;
      r_int_s2 <= '0;
    end else begin
      r_int_s1 <= int_i;
      r_int_s2 <= r_int_s1;
    end
  end

  assign w_int_pend = (|(r_int_s2 & status_i[15:10])) & status_i[0] & ~status_i[1];
  assign w_unused_status = ^{status_i[31:16], status_i[9:2]};
`else
  logic w_unused_in;
  assign w_int_pend  = 1'b0;
  assign w_unused_in = ^{int_i, status_i};
`endif

  // Fixed priority: interrupt, adel, ades, overflow, syscall, break, eret.
  always_comb begin
    w_evt = '0;
    if      (w_int_pend)     w_evt[6] = 1'b1;
    else if (mem_adel_i)     w_evt[5] = 1'b1;
    else if (mem_ades_i)     w_evt[4] = 1'b1;
    else if (mem_overflow_i) w_evt[3] = 1'b1;
    else if (mem_syscall_i)  w_evt[2] = 1'b1;
    else if (mem_break_i)    w_evt[1] = 1'b1;
    else if (mem_eret_i)     w_evt[0] = 1'b1;
  end

  assign w_take = (r_state == ST_IDLE) && mem_valid_i && (|w_evt);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_take) w_next = ST_FLUSH;
      ST_FLUSH:    w_next = ST_REDIRECT;
      ST_REDIRECT: if (fetch_ready_i) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_evt    <= '0;
      r_pc     <= '0;
      r_ds     <= 1'b0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_evt    <= w_evt;
        r_pc     <= mem_pc_i;
        r_ds     <= mem_delayslot_i;
        r_target <= w_evt[0] ? epc_i : EXC_VECTOR;
      end
    end
  end

  always_comb begin
    int_flag_o              = 1'b0;
    addr_read_error_flag_o  = 1'b0;
    addr_write_error_flag_o = 1'b0;
    overflow_flag_o         = 1'b0;
    syscall_flag_o          = 1'b0;
    break_flag_o            = 1'b0;
    eret_flag_o             = 1'b0;
    delayslot_flag_o        = 1'b0;
    flush_o                 = 1'b0;
    stall_o                 = 1'b0;
    redirect_valid_o        = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        {int_flag_o, addr_read_error_flag_o, addr_write_error_flag_o,
         overflow_flag_o, syscall_flag_o, break_flag_o, eret_flag_o} = r_evt;
        delayslot_flag_o = r_ds;
        flush_o          = 1'b1;
        stall_o          = 1'b1;
      end
      ST_REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign current_pc_addr_o = r_pc;
  assign redirect_pc_o     = r_target;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_delayslot_i;
  logic [31:0] mem_pc_i;
  logic        mem_syscall_i, mem_break_i, mem_overflow_i;
  logic        mem_adel_i, mem_ades_i, mem_eret_i;
  logic [5:0]  int_i;
  logic [31:0] status_i, epc_i;
  logic        fetch_ready_i;
  logic        syscall_flag_o, break_flag_o, overflow_flag_o;
  logic        addr_read_error_flag_o, addr_write_error_flag_o;
  logic        eret_flag_o, int_flag_o, delayslot_flag_o;
  logic [31:0] current_pc_addr_o, redirect_pc_o;
  logic        flush_o, stall_o, redirect_valid_o;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(EXC_VEC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_delayslot_i(mem_delayslot_i),
    .mem_syscall_i(mem_syscall_i), .mem_break_i(mem_break_i),
    .mem_overflow_i(mem_overflow_i), .mem_adel_i(mem_adel_i),
    .mem_ades_i(mem_ades_i), .mem_eret_i(mem_eret_i),
    .int_i(int_i), .status_i(status_i), .epc_i(epc_i), .fetch_ready_i(fetch_ready_i),
    .syscall_flag_o(syscall_flag_o), .break_flag_o(break_flag_o),
    .overflow_flag_o(overflow_flag_o), .addr_read_error_flag_o(addr_read_error_flag_o),
    .addr_write_error_flag_o(addr_write_error_flag_o), .eret_flag_o(eret_flag_o),
    .int_flag_o(int_flag_o), .delayslot_flag_o(delayslot_flag_o),
    .current_pc_addr_o(current_pc_addr_o), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;     // cycle in which the FLUSH pulse is expected
    logic [6:0]  flags;   // {int, adel, ades, ovf, sys, brk, eret}
    logic        ds;
    logic [31:0] pc;
    logic [31:0] target;
    int unsigned delay;   // REDIRECT cycles with fetch_ready low
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  logic [5:0] h1, h2;     // int_i driven one and two cycles ago

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] act_flags();
    return {int_flag_o, addr_read_error_flag_o, addr_write_error_flag_o,
            overflow_flag_o, syscall_flag_o, break_flag_o, eret_flag_o};
  endfunction

  // Monitor: compares DUT behaviour against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("flush_pulse", {31'b0, flush_o}, 1);
          chk("event_flags", {25'b0, act_flags()}, {25'b0, e.flags});
          chk("delayslot", {31'b0, delayslot_flag_o}, {31'b0, e.ds});
          chk("current_pc", current_pc_addr_o, e.pc);
          chk("stall_in_flush", {31'b0, stall_o}, 1);
          chk("no_redirect_in_flush", {31'b0, redirect_valid_o}, 0);
          for (int unsigned k = 0; k <= e.delay; k++) begin
            @(negedge clk);
            chk("redirect_valid", {31'b0, redirect_valid_o}, 1);
            chk("redirect_pc", redirect_pc_o, e.target);
            chk("stall_in_redirect", {31'b0, stall_o}, 1);
            chk("quiet_in_redirect", {24'b0, flush_o, act_flags()}, 0);
          end
        end else begin
          chk("idle_quiet", {22'b0, stall_o, redirect_valid_o, flush_o, act_flags()}, 0);
          if (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event: got no flush expected flush at cycle %0d", q[0].due);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic apply(input logic v, input logic [31:0] pc, input logic ds,
                       input logic [5:0] fl, input logic [5:0] irq,
                       input logic [31:0] st, input logic [31:0] epc, input logic rdy);
    mem_valid_i = v;
    mem_pc_i = pc;
    mem_delayslot_i = ds;
    {mem_adel_i, mem_ades_i, mem_overflow_i, mem_syscall_i, mem_break_i, mem_eret_i} = fl;
    int_i = irq;
    status_i = st;
    epc_i = epc;
    fetch_ready_i = rdy;
    h2 = h1;
    h1 = irq;
  endtask

  function automatic logic [31:0] rand_status();
    return {16'b0, 6'($urandom), 8'b0, 2'($urandom)};
  endfunction

  task automatic garbage(input logic rdy);
    apply(1'($urandom), $urandom, 1'($urandom), 6'($urandom), 6'($urandom),
          rand_status(), $urandom, rdy);
  endtask

  // Drives one MEM cycle; if an event should win, queues the expectation
  // and drives the busy period (random, ignored inputs) until fetch accepts.
  task automatic issue(input logic v, input logic [31:0] pc, input logic ds,
                       input logic [5:0] fl, input logic [5:0] irq,
                       input logic [31:0] st, input logic [31:0] epc,
                       input int unsigned delay);
    logic pend;
    logic [6:0] f;
    exp_t e;
    @(posedge clk); #1;
`ifdef EXC_INT_EN
    pend = (|(h2 & st[15:10])) && st[0] && !st[1];
`else
    pend = 1'b0;
`endif
    apply(v, pc, ds, fl, irq, st, epc, 1'($urandom));
    f = '0;
    if (v) begin
      if      (pend)  f[6] = 1'b1;
      else if (fl[5]) f[5] = 1'b1;
      else if (fl[4]) f[4] = 1'b1;
      else if (fl[3]) f[3] = 1'b1;
      else if (fl[2]) f[2] = 1'b1;
      else if (fl[1]) f[1] = 1'b1;
      else if (fl[0]) f[0] = 1'b1;
    end
    if (f != '0) begin
      e.due = cyc + 1;
      e.flags = f;
      e.ds = ds;
      e.pc = pc;
      e.target = f[0] ? epc : EXC_VEC;
      e.delay = delay;
      q.push_back(e);
      @(posedge clk); #1;
      garbage(1'($urandom));
      for (int unsigned k = 0; k <= delay; k++) begin
        @(posedge clk); #1;
        garbage(k == delay);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    h1 = '0;
    h2 = '0;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    h1 = '0;
    h2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {25'b0, act_flags()}, 0);
    chk("reset_ctrl", {29'b0, flush_o, stall_o, redirect_valid_o}, 0);
    chk("reset_ds", {31'b0, delayslot_flag_o}, 0);
    chk("reset_redirect_pc", redirect_pc_o, 0);
    chk("reset_current_pc", current_pc_addr_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    issue(1, 32'h00400020, 0, 6'b000100, 0, 0, 0, 0);            // syscall
    issue(1, 32'h00400024, 0, 6'b101100, 0, 0, 0, 1);            // adel+ovf+sys
    issue(1, 32'h00400040, 0, 6'b000001, 0, 0, 32'h00400100, 3); // eret, slow fetch
    issue(1, 32'h00400048, 0, 6'b000101, 0, 0, 32'h00400200, 0); // eret+syscall
    issue(1, 32'h00400044, 1, 6'b001000, 0, 0, 0, 0);            // overflow in delay slot
    issue(1, 32'h00400050, 0, 6'b000010, 0, 32'h2, 0, 0);        // break with EXL=1
    issue(1, 32'h00400054, 0, 6'b010000, 0, 0, 0, 2);            // ades
    issue(0, 32'h00400058, 0, 6'b000100, 0, 0, 0, 0);            // bubble: no event
    issue(1, 32'h0040005C, 0, 6'b000000, 0, 0, 0, 0);            // clean instruction
    for (int i = 0; i < 4; i++)                                  // interrupt path
      issue(1, 32'h00400060 + 4 * i, 0, 0, 6'b000001, 32'h401, 0, 0);
    for (int i = 0; i < 4; i++)                                  // masked by EXL
      issue(1, 32'h00400070 + 4 * i, 0, 0, 6'b000001, 32'h403, 0, 0);
    for (int i = 0; i < 3; i++)                                  // pending, no valid
      issue(0, 32'h00400080, 0, 0, 6'b000001, 32'h401, 0, 0);
    issue(1, 32'h00400084, 1, 6'b000010, 6'b000001, 32'h401, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] fl;
      for (int b = 0; b < 6; b++) fl[b] = ($urandom % 5 == 0);
      issue(($urandom % 4) != 0, $urandom, 1'($urandom), fl,
            ($urandom % 2) ? 6'($urandom) : 6'b0, rand_status(), $urandom,
            $urandom % 4);
    end

    // Reset while redirect is pending
    repeat (3) issue(0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b0;
    @(posedge clk); #1;
    apply(1, 32'h00400088, 0, 6'b000001, 0, 0, 32'h12345678, 0);
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("pre_reset_redirect_valid", {31'b0, redirect_valid_o}, 1);
    chk("pre_reset_redirect_pc", redirect_pc_o, 32'h12345678);
    @(posedge clk); #1;
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_redirect_valid", {31'b0, redirect_valid_o}, 0);
    chk("post_reset_stall", {31'b0, stall_o}, 0);
    chk("post_reset_redirect_pc", redirect_pc_o, 0);
    chk("post_reset_current_pc", current_pc_addr_o, 0);
    mon_en = 1'b1;
    issue(1, 32'h00400090, 0, 6'b000010, 0, 0, 0, 0);            // break after reset

    repeat (5) issue(0, 0, 0, 0, 0, 0, 0, 0);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller for the MEM stage. Collects per-instruction exception flags and external interrupt lines, picks one winning event per instruction, and sends one-cycle event pulses to the CP0 register block. It also flushes the pipeline and redirects fetch to the exception vector or to the EPC returned by CP0. Sits between the MEM pipeline register and CP0/fetch; it is CP0's sole source of exception flags.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc_i  in  32  PC of MEM instruction
- mem_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_syscall_i, mem_break_i, mem_overflow_i, mem_adel_i, mem_ades_i, mem_eret_i  in  1 each  per-instruction event flags
- int_i  in  6  asynchronous hardware interrupt lines
- status_i  in  32  CP0 Status (bit0 IE, bit1 EXL, bits15:10 IM7..IM2)
- epc_i  in  32  CP0 EPC
- fetch_ready_i  in  1  fetch accepts redirect this cycle
- syscall_flag_o, break_flag_o, overflow_flag_o, addr_read_error_flag_o, addr_write_error_flag_o, eret_flag_o, int_flag_o  out  1 each  one-hot event pulses to CP0
- delayslot_flag_o  out  1  delay-slot bit of the pulsed event
- current_pc_addr_o  out  32  PC of the pulsed instruction
- flush_o  out  1  kill IF..MEM contents
- stall_o  out  1  freeze pipeline advance
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target

## Operation
- Interrupt sync: int_i passes through 2 flops to int_sync[5:0]. int_pend = |(int_sync & status_i[15:10]) & status_i[0] & ~status_i[1].
- Event selection applies only in IDLE with mem_valid_i=1. Priority, highest first: int_pend, adel, ades, overflow, syscall, break, eret. Exactly one event wins.
- FSM states are IDLE, FLUSH and REDIRECT.
  - IDLE→FLUSH on a winning event. Register the event one-hot, mem_pc_i and mem_delayslot_i. Target is epc_i if eret wins, otherwise EXC_VECTOR.
  - FLUSH lasts one cycle. It drives exactly one *_flag_o, delayslot_flag_o, current_pc_addr_o and flush_o=1. Then FLUSH→REDIRECT.
  - REDIRECT holds redirect_valid_o=1 and redirect_pc_o stable until fetch_ready_i=1, then goes to IDLE on the next edge.
- stall_o=1 in FLUSH and REDIRECT. MEM inputs and int_pend are ignored outside IDLE.
- An exception raised while status_i[1]=1 is still pulsed, flushed and redirected. CP0 decides whether EPC and BD update.
- Eret and an exception on the same instruction: the exception wins and eret_flag_o stays 0.
- mem_valid_i=0 in IDLE: no event, even if int_pend=1. The interrupt waits for the next valid instruction.

## Timing
- Reset values: all outputs 0, redirect_pc_o=0, current_pc_addr_o=0, FSM=IDLE, int_sync=0.
- Event sampled at edge E. FLUSH is the cycle after E, with pulses and flush_o. CP0 latches at the end of that cycle. redirect_valid_o rises one cycle later.
- Minimum event-to-IDLE is 3 cycles, when fetch_ready_i=1 in the first REDIRECT cycle.
- int_i to int_pend latency is 2 cycles.
- rst in any state: IDLE on the next edge, all outputs 0, pending redirect dropped.

## Configuration
- EXC_INT_EN defined: interrupt synchronizer and int_flag_o are active as described.
- EXC_INT_EN undefined: no synchronizer flops, int_pend tied 0, int_flag_o tied 0, int_i ignored. All other behaviour is unchanged.

## Test plan
- syscall at mem_pc_i=0x00400020, delayslot=0 -> next cycle syscall_flag_o=1, current_pc_addr_o=0x00400020, flush_o=1; following cycle redirect_pc_o=0xBFC00380.
- adel+overflow+syscall same cycle -> only addr_read_error_flag_o pulses, one cycle wide.
- eret with epc_i=0x00400100, fetch_ready_i low 3 cycles -> redirect_valid_o held 4 cycles at 0x00400100, stall_o high throughout, then IDLE.
- int_i[0]=1, status_i=0x0000_0401 (IE=1, IM2=1), valid instruction -> int_flag_o fires no earlier than 3 edges after int_i rises; same test with status_i[1]=1 -> no event.
- overflow with delayslot=1 at 0x00400044 -> delayslot_flag_o=1, current_pc_addr_o=0x00400044.
- rst asserted during REDIRECT -> next cycle redirect_valid_o=0, stall_o=0; a subsequent break is handled normally.
